one_of_n_arb_reg: RTL and testbench
===================================

// Module: one_of_n_arb_reg
// PURPOSE
//  Parametrised successor to the combinational N:1 output mux of the dynamic node. Selects one of
//  N input channels by round-robin, holds the grant for a whole wormhole packet, and registers the
//  winner's flits into a single output stage with valid/ready handshake. Sits at each dynamic-node
//  output port, between the per-input FIFOs and the link driver.
// PARAMETERS
//  N        5   number of input channels (>=1)
//  WIDTH    64  flit width in bits
//  LEN_LSB  22  LSB of the payload-length field in the header flit
//  LEN_W    8   width of the payload-length field (body flits following the header)
//  SEL_W    derived: max(1,$clog2(N)); not to be overridden
// PORTS
//  clk       in   1         clock
//  rst_n     in   1         asynchronous active-low reset
//  in_data   in   N*WIDTH   flits; channel i at [i*WIDTH +: WIDTH]
//  in_valid  in   N         channel i has a flit
//  in_ready  out  N         flit on channel i accepted this cycle when in_valid[i]&in_ready[i]
//  out_data  out  WIDTH     registered output flit
//  out_valid out  1         out_data valid
//  out_ready in   1         downstream accepts out_data this cycle
//  busy      out  1         1 while a packet is in progress (state ROUTE)
//  cur_sel   out  SEL_W     currently/last granted channel
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, in_ready=0, busy=0, cur_sel=0, rr_ptr=0, remaining=0, state IDLE.
//  Output stage: space = ~out_valid | out_ready. Load on accept; else clear out_valid on out_ready.
//  IDLE: if space & |in_valid: grant g = first valid channel at/after rr_ptr (wrapping mod N);
//   in_ready[g]=1 same cycle, header loaded, remaining <= header[LEN_LSB+:LEN_W], cur_sel<=g.
//   len==0: single-flit packet, stay IDLE, rr_ptr <= (g+1)%N. len>0: go ROUTE.
//  ROUTE: in_ready[cur_sel]=space; all other in_ready=0. Each accept decrements remaining; accept
//   with remaining==1 (tail) -> IDLE, rr_ptr <= (cur_sel+1)%N. Other channels' valids ignored.
//  Latency: flit accepted in cycle t appears on out_data at t+1. Full throughput (1 flit/cycle)
//   with out_ready held high; packet-to-packet switch after a tail costs no bubble in IDLE
//   (arbitration is combinational from registered rr_ptr).
//  in_ready never depends on in_valid of the same channel (no comb loop); at most one bit set.
//  Stall: out_valid & ~out_ready -> out_data/out_valid held stable, no in_ready asserted.
//  N==1: rr_ptr constant 0; packet framing still honoured.
//  Reset mid-packet: all state discarded, partially forwarded packet is not resumed.
//  remaining is LEN_W bits; len=2^LEN_W-1 must work without wrap.
// CONFIGURATION
//  ONE_OF_N_ARB_STATS_EN defined: extra output stat_pkt_cnt [N*16] — per-channel 16-bit counters,
//   +1 on each header accept of that channel, saturate at 16'hFFFF, cleared by rst_n.
//  Undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Package one_of_n_arb_pkg: LEN_LSB/LEN_W defaults, state enum (IDLE, ROUTE), STAT_W=16.
//  Sub-module rr_pick (combinational: req[N], ptr[SEL_W] -> gnt_idx, gnt_any), reusable elsewhere.
//  Top: FSM, remaining counter, rr_ptr, output register, optional stats block.
// TESTING
//  1 Reset: rst_n low mid-ROUTE with out_valid=1 -> all outputs 0 immediately, busy=0.
//  2 N=5, all valid, len=0 headers, out_ready=1 -> grants 0,1,2,3,4,0 on consecutive cycles.
//  3 ch2 sends len=3 packet while ch0/ch4 valid -> 4 flits of ch2 back-to-back, then ch4, then ch0.
//  4 out_ready low 3 cycles mid-packet -> out_data stable, in_ready all 0, no flit lost/duplicated.
//  5 len=255 packet on ch1 -> exactly 256 flits forwarded, then busy=0.
//  6 STATS_EN: 70000 single-flit packets on ch3 -> stat_pkt_cnt[3] = 16'hFFFF, others 0.

Source files
------------

// File: rtl/one_of_n_arb_pkg.sv
// one_of_n_arb_pkg: shared defaults and FSM state type for the registered N:1 packet arbiter
package one_of_n_arb_pkg;

    localparam int LEN_LSB_DEF = 22;
    localparam int LEN_W_DEF   = 8;
    localparam int STAT_W      = 16;

    typedef enum logic {
        IDLE,
        ROUTE
    } state_t;

endpackage

// File: rtl/one_of_n_arb_reg_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req at/after ptr wrapping modulo N
module rr_pick #(
    parameter int N     = 5,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int idx;

    // scan from the far end back to ptr so the nearest requester is assigned last and wins
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx[SEL_W-1:0]]) begin
                gnt_idx = idx[SEL_W-1:0];
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/one_of_n_arb_reg.sv
// one_of_n_arb_reg: round-robin N:1 wormhole arbiter with registered output stage
// Optional per-channel packet counters on stat_pkt_cnt when ONE_OF_N_ARB_STATS_EN is defined.
module one_of_n_arb_reg
    import one_of_n_arb_pkg::*;
#(
    parameter int N       = 5,
    parameter int WIDTH   = 64,
    parameter int LEN_LSB = LEN_LSB_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    localparam int SEL_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
`ifdef ONE_OF_N_ARB_STATS_EN
    output logic [N*STAT_W-1:0] stat_pkt_cnt,
`endif
    output logic [SEL_W-1:0]   cur_sel
);

    state_t             state, state_next;
    logic [SEL_W-1:0]   rr_ptr, gnt_idx, sel, nxt;
    logic [LEN_W-1:0]   remaining, len;
    logic [WIDTH-1:0]   flit;
    logic               gnt_any, space, hdr, accept, last;

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // channel selection, ready generation, framing and next state
    always_comb begin
        space      = ~out_valid | out_ready;
        hdr        = (state == IDLE);
        sel        = hdr ? gnt_idx : cur_sel;
        in_ready   = '0;
        in_ready[sel] = rst_n & space & (hdr ? gnt_any : 1'b1);
        flit       = in_data[sel*WIDTH +: WIDTH];
        accept     = |(in_valid & in_ready);
        len        = flit[LEN_LSB +: LEN_W];
        last       = hdr ? (len == '0) : (remaining == LEN_W'(1));
        nxt        = (sel == SEL_W'(N - 1)) ? '0 : sel + 1'b1;
        state_next = accept ? (last ? IDLE : ROUTE) : state;
        busy       = (state == ROUTE);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // output register, packet length tracking and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            cur_sel   <= '0;
            rr_ptr    <= '0;
            remaining <= '0;
        end else begin
            out_valid <= accept | (out_valid & ~out_ready);
            if (accept) begin
                out_data  <= flit;
                cur_sel   <= sel;
                remaining <= hdr ? len : remaining - 1'b1;
                if (last) rr_ptr <= nxt;
            end
        end
    end

`ifdef ONE_OF_N_ARB_STATS_EN
    for (genvar i = 0; i < N; i++) begin : g_stat
        logic [STAT_W-1:0] cnt;
        // saturating count of headers accepted from channel i
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                     cnt <= '0;
            else if (accept & hdr & (sel == SEL_W'(i)) & ~&cnt) cnt <= cnt + 1'b1;
        end
        assign stat_pkt_cnt[i*STAT_W +: STAT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_one_of_n_arb_reg.sv
// tb_one_of_n_arb_reg: scoreboard bench for the round-robin registered packet arbiter
module tb_one_of_n_arb_reg;

    localparam int N = 5;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid, out_ready, busy;
    logic [2:0]     cur_sel;
`ifdef ONE_OF_N_ARB_STATS_EN
    logic [N*16-1:0] stat_pkt_cnt;
`endif

    logic [63:0] srcq[N][$];
    logic [63:0] expq[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc;

    always #5 clk = ~clk;

    one_of_n_arb_reg #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
`ifdef ONE_OF_N_ARB_STATS_EN
        .stat_pkt_cnt (stat_pkt_cnt),
`endif
        .cur_sel   (cur_sel)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] flit(int ch, int pkt, int idx, int len);
        return {4'(ch), 12'(pkt), 16'(idx), 2'b0, 8'(len), 22'h0};
    endfunction

    task automatic send(int ch, int pkt, int len);
        for (int i = 0; i <= len; i++) srcq[ch].push_back(flit(ch, pkt, i, len));
    endtask

    task automatic expect_pkt(int ch, int pkt, int len);
        for (int i = 0; i <= len; i++) expq.push_back(flit(ch, pkt, i, len));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i]         = srcq[i].size() > 0;
            in_data[i*W +: W]   = (srcq[i].size() > 0) ? srcq[i][0] : 64'h0;
        end
    endtask

    task automatic step();
        logic [N-1:0] acc;
        logic         ob;
        logic [63:0]  od, af;
        @(negedge clk);
        acc = in_valid & in_ready;
        ob  = out_valid & out_ready;
        od  = out_data;
        af  = 64'h0;
        check("rdy_onehot", 64'($countones(in_ready) <= 1), 64'd1);
        for (int i = 0; i < N; i++) if (acc[i]) af = in_data[i*W +: W];
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) void'(srcq[i].pop_front());
        if (ob) begin
            if (expq.size() > 0) check("out_flit", od, expq.pop_front());
            else                 check("out_unexpected", {63'b0, ob}, 64'd0);
        end
        if (|acc) begin
            check("lat_valid", {63'b0, out_valid}, 64'd1);
            check("lat_data", out_data, af);
        end
        drive();
    endtask

    task automatic run(input int budget, output int n);
        n = 0;
        while (expq.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (expq.size() > 0) check("timeout_pending", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        out_ready = 1'b1;
        in_valid  = '1;
        in_data   = '0;
        #12;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_in_ready", {59'b0, in_ready}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_cur_sel", {61'b0, cur_sel}, 64'd0);
        in_valid = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // all channels valid with single-flit packets: grants 0,1,2,3,4,0
        for (int c = 0; c < N; c++) send(c, 1, 0);
        send(0, 2, 0);
        for (int c = 0; c < N; c++) expect_pkt(c, 1, 0);
        expect_pkt(0, 2, 0);
        drive();
        run(20, cyc);
        check("t2_cycles", 64'(cyc), 64'd7);

        // ch2 multi-flit packet wins from rr_ptr=1, then ch4, then ch0
        send(2, 3, 3);
        send(0, 4, 0);
        send(4, 5, 0);
        expect_pkt(2, 3, 3);
        expect_pkt(4, 5, 0);
        expect_pkt(0, 4, 0);
        drive();
        run(20, cyc);
        check("t3_cycles", 64'(cyc), 64'd7);

        // downstream stall mid-packet
        send(3, 40, 5);
        expect_pkt(3, 40, 5);
        drive();
        repeat (3) step();
        out_ready = 1'b0;
        repeat (3) begin
            step();
            check("stall_data", out_data, flit(3, 40, 2, 5));
            check("stall_valid", {63'b0, out_valid}, 64'd1);
            check("stall_rdy", {59'b0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        run(20, cyc);
        check("t4_busy_end", {63'b0, busy}, 64'd0);

        // maximum length packet
        send(1, 50, 255);
        expect_pkt(1, 50, 255);
        drive();
        step();
        check("t5_busy", {63'b0, busy}, 64'd1);
        run(400, cyc);
        check("t5_cycles", 64'(cyc), 64'd256);
        check("t5_busy_end", {63'b0, busy}, 64'd0);
        check("t5_cur_sel", {61'b0, cur_sel}, 64'd1);

        // reset in the middle of a packet
        send(0, 60, 10);
        expq.push_back(flit(0, 60, 0, 10));
        expq.push_back(flit(0, 60, 1, 10));
        drive();
        repeat (3) step();
        check("t1_busy_pre", {63'b0, busy}, 64'd1);
        check("t1_valid_pre", {63'b0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("t1_out_valid", {63'b0, out_valid}, 64'd0);
        check("t1_out_data", out_data, 64'd0);
        check("t1_in_ready", {59'b0, in_ready}, 64'd0);
        check("t1_busy", {63'b0, busy}, 64'd0);
        check("t1_cur_sel", {61'b0, cur_sel}, 64'd0);
        for (int c = 0; c < N; c++) srcq[c].delete();
        drive();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(2, 70, 0);
        expect_pkt(2, 70, 0);
        drive();
        run(10, cyc);
        check("t1_after_sel", {61'b0, cur_sel}, 64'd2);
        check("t1_after_busy", {63'b0, busy}, 64'd0);

`ifdef ONE_OF_N_ARB_STATS_EN
        // saturating per-channel packet counters
        rst_n = 1'b0;
        #1;
        check("t6_rst_cnt", {16'b0, stat_pkt_cnt[47:0]} | {48'b0, stat_pkt_cnt[79:64]}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_data[3*W +: W] = flit(3, 0, 0, 0);
        in_valid = 5'b01000;
        repeat (70010) @(posedge clk);
        #1;
        in_valid = '0;
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++)
            check("t6_stat", {48'b0, stat_pkt_cnt[c*16 +: 16]}, (c == 3) ? 64'hFFFF : 64'd0);
`endif

        check("final_expq", 64'(expq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
